npu_seq: RTL and testbench

Host-mapped layer sequencer for the NPU datapath. It runs a programmable number of conv passes, then the FC stage, without per-layer host pokes. It drives conv/fcn control strobes, stages FC1 weight lanes, and exposes status, pixel count and logit through a registered read port. It sits between the 32-bit host BRAM-style port and the conv / partial_sum / fcn engines.

---
 rtl/npu_seq.sv | 271 +++++++++++++++++++++++++++
 tb/tb_npu_seq.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/npu_seq.sv
// npu_seq: host-mapped layer sequencer driving conv passes, then the FC stage.
// Optional watchdog built when NPU_SEQ_WDOG_EN is defined.
module npu_seq #(
   parameter int NUM_LAYERS = 2,
   parameter int NUM_PE     = 4,
   parameter int PIX_CNT    = 132,
   parameter int LOGIT_W    = 24,
   parameter int WDOG_CYC   = 4096
) (
   input  logic                      clk,
   input  logic                      rst_ni,
   input  logic                      ena,
   input  logic                      wea,
   input  logic [15:0]               addra,
   input  logic [31:0]               dina,
   output logic [31:0]               douta,
   output logic                      conv_clear,
   output logic                      conv_trigger,
   output logic [3:0]                conv_layer,
   output logic                      sum_clear,
   input  logic                      conv_valid,
   output logic                      fcn_start,
   output logic                      fc1_next,
   input  logic                      fc1_valid,
   output logic [8*NUM_PE-1:0]       w_stream,
   input  logic                      fcn_done,
   input  logic signed [LOGIT_W-1:0] fcn_logit,
   output logic                      irq
);

   localparam int PIX_W = $clog2(PIX_CNT + 1);
   localparam int NGRP  = NUM_PE / 4;

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_CLR      = 3'd1,
      S_CONV     = 3'd2,
      S_NEXT     = 3'd3,
      S_FC_START = 3'd4,
      S_FC_RUN   = 3'd5,
      S_DONE     = 3'd6
   } state_t;

   function automatic logic [3:0] clamp_lcnt(input logic [3:0] v);
      if (v == 4'd0 || int'(v) > NUM_LAYERS) return 4'(NUM_LAYERS);
      return v;
   endfunction

   function automatic logic [31:0] sext_logit(input logic signed [LOGIT_W-1:0] v);
      return 32'(v);
   endfunction

   state_t                     state;
   logic [3:0]                 lcnt;
   logic [PIX_W-1:0]           pix_cnt;
   logic [8*NUM_PE-1:0]        staging;
   logic signed [LOGIT_W-1:0]  logit_r;
   logic                       done_st, err_start, err_abort, err_wdog, fc1_req;
   logic                       wdog_hit;

   logic                       ena_p0, wea_p0;
   logic [14:0]                addr_p0;
   logic [31:0]                din_p0;
   logic                       unused_addr;

   assign unused_addr = addra[15];

   // p0: host port register stage
   always_ff @(posedge clk or negedge rst_ni) begin
      if (!rst_ni) begin
         ena_p0  <= 1'b0;
         wea_p0  <= 1'b0;
         addr_p0 <= '0;
         din_p0  <= '0;
      end else begin
         ena_p0  <= ena;
         wea_p0  <= wea;
         addr_p0 <= addra[14:0];
         din_p0  <= dina;
      end
   end

   logic        wr_p0, ctrl_wr, start_cmd, abort_cmd, commit_cmd, stage_wr;
   logic [2:0]  sel_p0;
   logic [11:0] idx_p0;

   assign sel_p0     = addr_p0[14:12];
   assign idx_p0     = addr_p0[11:0];
   assign wr_p0      = ena_p0 & wea_p0;
   assign ctrl_wr    = wr_p0 && (sel_p0 == 3'b101) && (idx_p0 == 12'd0);
   assign start_cmd  = ctrl_wr & din_p0[0];
   assign abort_cmd  = ctrl_wr & din_p0[1];
   assign commit_cmd = wr_p0 && (sel_p0 == 3'b101) && (idx_p0 == 12'd1);
   assign stage_wr   = wr_p0 && (sel_p0 == 3'b011);

   // Reads bypass the p0 stage so douta lands one cycle after the request.
   logic        rd_req, status_rd;
   logic [2:0]  rd_sel;
   logic [11:0] rd_idx;
   logic [31:0] status_word, pix_word;

   assign rd_req      = ena & ~wea;
   assign rd_sel      = addra[14:12];
   assign rd_idx      = addra[11:0];
   assign status_rd   = rd_req && (rd_sel == 3'b110) && (rd_idx == 12'd0);
   assign status_word = {16'd0, conv_layer, 3'd0, fc1_req, err_wdog, err_abort,
                         err_start, done_st, (state != S_IDLE), 3'(state)};
   assign pix_word    = 32'(pix_cnt);

`ifdef NPU_SEQ_WDOG_EN
   localparam int WD_W = $clog2(WDOG_CYC + 1);
   logic [WD_W-1:0] wdog_cnt;
   logic            wdog_run, wdog_kick;

   assign wdog_run  = (state == S_CONV) || (state == S_FC_RUN);
   assign wdog_kick = conv_valid | fc1_valid | commit_cmd;
   assign wdog_hit  = wdog_run && !wdog_kick && (wdog_cnt == WD_W'(WDOG_CYC - 1));

   always_ff @(posedge clk or negedge rst_ni) begin
      if (!rst_ni)                               wdog_cnt <= '0;
      else if (!wdog_run || wdog_kick || wdog_hit) wdog_cnt <= '0;
      else                                       wdog_cnt <= wdog_cnt + WD_W'(1);
   end
`else
   logic unused_wdog;
   assign wdog_hit    = 1'b0;
   assign unused_wdog = (WDOG_CYC != 0);
`endif

   // p1: sequencer state, sticky status and registered strobes
   always_ff @(posedge clk or negedge rst_ni) begin
      if (!rst_ni) begin
         state        <= S_IDLE;
         lcnt         <= 4'(NUM_LAYERS);
         pix_cnt      <= '0;
         conv_layer   <= '0;
         conv_clear   <= 1'b1;
         conv_trigger <= 1'b0;
         sum_clear    <= 1'b0;
         fcn_start    <= 1'b0;
         fc1_next     <= 1'b0;
         irq          <= 1'b0;
         w_stream     <= '0;
         staging      <= '0;
         logit_r      <= '0;
         done_st      <= 1'b0;
         err_start    <= 1'b0;
         err_abort    <= 1'b0;
         err_wdog     <= 1'b0;
         fc1_req      <= 1'b0;
      end else begin
         conv_trigger <= 1'b0;
         sum_clear    <= 1'b0;
         fcn_start    <= 1'b0;
         fc1_next     <= 1'b0;
         irq          <= 1'b0;

         // Read-clear first; any set below in the same cycle overrides it.
         if (status_rd) begin
            done_st   <= 1'b0;
            err_start <= 1'b0;
            err_abort <= 1'b0;
            err_wdog  <= 1'b0;
            fc1_req   <= 1'b0;
         end

         if (stage_wr) begin
            for (int g = 0; g < NGRP; g++) begin
               if (idx_p0 == 12'(g)) staging[32*g +: 32] <= din_p0;
            end
         end

         if (abort_cmd && state != S_IDLE) begin
            state      <= S_IDLE;
            conv_clear <= 1'b1;
            pix_cnt    <= '0;
            conv_layer <= '0;
            err_abort  <= 1'b1;
            irq        <= 1'b1;
         end else begin
            if (start_cmd && state != S_IDLE) begin
               err_start <= 1'b1;
               irq       <= 1'b1;
            end
            case (state)
               S_IDLE: begin
                  conv_clear <= 1'b1;
                  if (start_cmd && !abort_cmd) begin
                     state      <= S_CLR;
                     lcnt       <= clamp_lcnt(din_p0[7:4]);
                     conv_layer <= '0;
                     pix_cnt    <= '0;
                     sum_clear  <= 1'b1;
                  end
               end
               S_CLR: begin
                  state        <= S_CONV;
                  conv_clear   <= 1'b0;
                  conv_trigger <= 1'b1;
               end
               S_CONV: begin
                  if (conv_valid) begin
                     pix_cnt <= pix_cnt + PIX_W'(1);
                     if (pix_cnt == PIX_W'(PIX_CNT - 1)) state <= S_NEXT;
                  end
               end
               S_NEXT: begin
                  if ((conv_layer + 4'd1) < lcnt) begin
                     conv_layer <= conv_layer + 4'd1;
                     pix_cnt    <= '0;
                     conv_clear <= 1'b1;
                     state      <= S_CLR;
                  end else begin
                     fcn_start <= 1'b1;
                     state     <= S_FC_START;
                  end
               end
               S_FC_START: state <= S_FC_RUN;
               S_FC_RUN: begin
                  if (commit_cmd) begin
                     w_stream <= staging;
                     fc1_next <= 1'b1;
                     fc1_req  <= 1'b0;
                  end
                  if (fc1_valid) fc1_req <= 1'b1;
                  if (fcn_done) begin
                     logit_r <= fcn_logit;
                     state   <= S_DONE;
                  end
               end
               S_DONE: begin
                  done_st    <= 1'b1;
                  irq        <= 1'b1;
                  conv_clear <= 1'b1;
                  state      <= S_IDLE;
               end
               default: begin
                  conv_clear <= 1'b1;
                  state      <= S_IDLE;
               end
            endcase
            if (wdog_hit) begin
               state      <= S_IDLE;
               conv_clear <= 1'b1;
               pix_cnt    <= '0;
               conv_layer <= '0;
               err_wdog   <= 1'b1;
               irq        <= 1'b1;
            end
         end
      end
   end

   // p1: registered host read port
   always_ff @(posedge clk or negedge rst_ni) begin
      if (!rst_ni) begin
         douta <= '0;
      end else if (rd_req) begin
         douta <= '0;
         if (rd_sel == 3'b110) begin
            case (rd_idx)
               12'd0:   douta <= status_word;
               12'd1:   douta <= sext_logit(logit_r);
               12'd2:   douta <= pix_word;
               default: douta <= '0;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_npu_seq.sv
// Directed self-checking bench for npu_seq; one task per scenario.
module tb_npu_seq;

   localparam int PIX = 132;
   localparam logic [15:0] A_STAGE0 = 16'h3000;
   localparam logic [15:0] A_STAGE1 = 16'h3001;
   localparam logic [15:0] A_CTRL   = 16'h5000;
   localparam logic [15:0] A_COMMIT = 16'h5001;
   localparam logic [15:0] A_STATUS = 16'h6000;
   localparam logic [15:0] A_LOGIT  = 16'h6001;
   localparam logic [15:0] A_PIX    = 16'h6002;

   logic               clk = 1'b0;
   logic               rst_ni = 1'b0;
   logic               ena = 1'b0, wea = 1'b0;
   logic [15:0]        addra = '0;
   logic [31:0]        dina = '0;
   logic [31:0]        douta;
   logic               conv_clear, conv_trigger, sum_clear, fcn_start, fc1_next, irq;
   logic [3:0]         conv_layer;
   logic               conv_valid = 1'b0, fc1_valid = 1'b0, fcn_done = 1'b0;
   logic [31:0]        w_stream;
   logic signed [23:0] fcn_logit = '0;

   int chk_cnt = 0, pass_cnt = 0;
   int irq_cnt = 0, trig_cnt = 0, fstart_cnt = 0, next_cnt = 0, sclr_cnt = 0;

   npu_seq #(.NUM_LAYERS(2), .NUM_PE(4), .PIX_CNT(PIX), .LOGIT_W(24), .WDOG_CYC(16)) dut (
      .clk(clk), .rst_ni(rst_ni), .ena(ena), .wea(wea), .addra(addra), .dina(dina),
      .douta(douta), .conv_clear(conv_clear), .conv_trigger(conv_trigger),
      .conv_layer(conv_layer), .sum_clear(sum_clear), .conv_valid(conv_valid),
      .fcn_start(fcn_start), .fc1_next(fc1_next), .fc1_valid(fc1_valid),
      .w_stream(w_stream), .fcn_done(fcn_done), .fcn_logit(fcn_logit), .irq(irq)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (irq === 1'b1)          irq_cnt++;
      if (conv_trigger === 1'b1) trig_cnt++;
      if (fcn_start === 1'b1)    fstart_cnt++;
      if (fc1_next === 1'b1)     next_cnt++;
      if (sum_clear === 1'b1)    sclr_cnt++;
   end

   initial begin
      #3000000;
      $display("FAIL global_timeout: got no finish want finish before 3ms");
      $fatal(1, "timeout");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Write is registered on the first edge and acts on the second.
   task automatic host_wr(input logic [15:0] a, input logic [31:0] d);
      ena = 1'b1; wea = 1'b1; addra = a; dina = d;
      tick();
      ena = 1'b0; wea = 1'b0;
      tick();
   endtask

   task automatic host_rd(input logic [15:0] a, output logic [31:0] d);
      ena = 1'b1; wea = 1'b0; addra = a;
      tick();
      ena = 1'b0;
      d = douta;
   endtask

   task automatic run_pass(input logic [3:0] exp_layer, input int npix, input string tag);
      bit seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         tick();
         if (conv_trigger === 1'b1) seen = 1'b1;
      end
      chk_cnt++;
      if (!seen) $display("FAIL %s_trigger: got none want conv_trigger within 20 cycles", tag);
      else if (conv_layer !== exp_layer) $display("FAIL %s_layer: got %0d want %0d", tag, conv_layer, exp_layer);
      else pass_cnt++;
      conv_valid = 1'b1;
      repeat (npix) tick();
      conv_valid = 1'b0;
   endtask

   task automatic wait_fcn_start(input string tag);
      bit seen = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
         tick();
         if (fcn_start === 1'b1) seen = 1'b1;
      end
      chk_cnt++;
      if (!seen) $display("FAIL %s_fcn_start: got none want pulse within 10 cycles", tag);
      else pass_cnt++;
   endtask

   task automatic test_reset();
      logic [31:0] rd;
      rst_ni = 1'b0;
      repeat (3) tick();
      rst_ni = 1'b1;
      tick();
      chk_cnt++;
      if ({conv_clear, conv_trigger, sum_clear, fcn_start, fc1_next, irq} !== 6'b100000)
         $display("FAIL reset_strobes: got %b want 100000",
                  {conv_clear, conv_trigger, sum_clear, fcn_start, fc1_next, irq});
      else pass_cnt++;
      chk_cnt++;
      if (conv_layer !== 4'd0 || w_stream !== 32'd0 || douta !== 32'd0)
         $display("FAIL reset_data: got layer=%0d w=%h douta=%h want 0 0 0", conv_layer, w_stream, douta);
      else pass_cnt++;
      host_rd(A_STATUS, rd);
      chk_cnt++;
      if (rd !== 32'h0) $display("FAIL reset_status: got %h want 00000000", rd); else pass_cnt++;
   endtask

   task automatic test_full_run();
      logic [31:0] rd;
      int irq0 = irq_cnt, trig0 = trig_cnt, fs0 = fstart_cnt, nx0 = next_cnt;
      host_wr(A_CTRL, 32'h21);
      chk_cnt++;
      if (sum_clear !== 1'b1) $display("FAIL run_sum_clear: got %b want 1", sum_clear); else pass_cnt++;
      run_pass(4'd0, PIX, "run_p0");
      run_pass(4'd1, PIX, "run_p1");
      wait_fcn_start("run");
      chk_cnt++;
      if (trig_cnt - trig0 !== 2) $display("FAIL run_trig_count: got %0d want 2", trig_cnt - trig0); else pass_cnt++;
      tick();
      fc1_valid = 1'b1; tick(); fc1_valid = 1'b0;
      host_wr(A_STAGE0, 32'h0403_0201);
      host_wr(A_COMMIT, 32'h0);
      chk_cnt++;
      if (fc1_next !== 1'b1 || w_stream !== 32'h0403_0201)
         $display("FAIL commit: got next=%b w=%h want 1 04030201", fc1_next, w_stream);
      else pass_cnt++;
      chk_cnt++;
      if (w_stream[7:0] !== 8'h01 || w_stream[31:24] !== 8'h04)
         $display("FAIL commit_lanes: got l0=%h l3=%h want 01 04", w_stream[7:0], w_stream[31:24]);
      else pass_cnt++;
      tick();
      chk_cnt++;
      if (fc1_next !== 1'b0) $display("FAIL commit_pulse_width: got %b want 0", fc1_next); else pass_cnt++;
      host_rd(A_STATUS, rd);
      chk_cnt++;
      if (rd !== 32'h100D) $display("FAIL fc1_req_commit_clear: got %h want 0000100d", rd); else pass_cnt++;
      fc1_valid = 1'b1; tick(); fc1_valid = 1'b0;
      host_rd(A_STATUS, rd);
      chk_cnt++;
      if (rd !== 32'h110D) $display("FAIL fc1_req_set: got %h want 0000110d", rd); else pass_cnt++;
      host_rd(A_STATUS, rd);
      chk_cnt++;
      if (rd !== 32'h100D) $display("FAIL fc1_req_read_clear: got %h want 0000100d", rd); else pass_cnt++;
      fcn_logit = -24'sd5;
      fcn_done = 1'b1; tick(); fcn_done = 1'b0;
      tick();
      chk_cnt++;
      if (irq !== 1'b1 || conv_clear !== 1'b1)
         $display("FAIL done_irq: got irq=%b clr=%b want 1 1", irq, conv_clear);
      else pass_cnt++;
      host_rd(A_LOGIT, rd);
      chk_cnt++;
      if (rd !== 32'hFFFF_FFFB) $display("FAIL logit: got %h want fffffffb", rd); else pass_cnt++;
      host_rd(A_STATUS, rd);
      chk_cnt++;
      if (rd !== 32'h1010) $display("FAIL done_status: got %h want 00001010", rd); else pass_cnt++;
      host_rd(A_PIX, rd);
      chk_cnt++;
      if (rd !== 32'd132) $display("FAIL done_pix: got %h want 00000084", rd); else pass_cnt++;
      chk_cnt++;
      if (irq_cnt - irq0 !== 1 || fstart_cnt - fs0 !== 1 || next_cnt - nx0 !== 1)
         $display("FAIL run_pulse_counts: got irq=%0d fs=%0d nx=%0d want 1 1 1",
                  irq_cnt - irq0, fstart_cnt - fs0, next_cnt - nx0);
      else pass_cnt++;
   endtask

   task automatic test_start_busy_abort();
      logic [31:0] rd;
      int irq0 = irq_cnt;
      host_wr(A_CTRL, 32'h01);
      run_pass(4'd0, 50, "abort");
      host_wr(A_CTRL, 32'h01);
      host_rd(A_STATUS, rd);
      chk_cnt++;
      if (rd !== 32'h2A) $display("FAIL err_start_status: got %h want 0000002a", rd); else pass_cnt++;
      host_rd(A_PIX, rd);
      chk_cnt++;
      if (rd !== 32'd50) $display("FAIL pix_50: got %h want 00000032", rd); else pass_cnt++;
      host_wr(A_CTRL, 32'h02);
      chk_cnt++;
      if (conv_clear !== 1'b1 || conv_layer !== 4'd0)
         $display("FAIL abort_outputs: got clr=%b layer=%0d want 1 0", conv_clear, conv_layer);
      else pass_cnt++;
      host_rd(A_PIX, rd);
      chk_cnt++;
      if (rd !== 32'd0) $display("FAIL abort_pix: got %h want 00000000", rd); else pass_cnt++;
      host_rd(A_STATUS, rd);
      chk_cnt++;
      if (rd !== 32'h40) $display("FAIL abort_status: got %h want 00000040", rd); else pass_cnt++;
      host_rd(A_STATUS, rd);
      chk_cnt++;
      if (rd !== 32'h0) $display("FAIL status_reread: got %h want 00000000", rd); else pass_cnt++;
      chk_cnt++;
      if (irq_cnt - irq0 !== 2) $display("FAIL abort_irq_count: got %0d want 2", irq_cnt - irq0); else pass_cnt++;
   endtask

   task automatic test_lcnt_clamp_abort_done();
      logic [31:0] rd;
      int trig0 = trig_cnt;
      host_wr(A_CTRL, 32'hF1);
      run_pass(4'd0, PIX, "clamp_p0");
      run_pass(4'd1, PIX, "clamp_p1");
      wait_fcn_start("clamp");
      chk_cnt++;
      if (trig_cnt - trig0 !== 2) $display("FAIL clamp_trig_count: got %0d want 2", trig_cnt - trig0); else pass_cnt++;
      tick();
      host_wr(A_STAGE0, 32'h1122_3344);
      host_wr(A_STAGE1, 32'hAABB_CCDD);
      host_wr(A_COMMIT, 32'h0);
      chk_cnt++;
      if (w_stream !== 32'h1122_3344) $display("FAIL stage_idx_drop: got %h want 11223344", w_stream); else pass_cnt++;
      ena = 1'b1; wea = 1'b1; addra = A_CTRL; dina = 32'h2;
      tick();
      ena = 1'b0; wea = 1'b0;
      fcn_logit = 24'sd7; fcn_done = 1'b1;
      tick();
      fcn_done = 1'b0;
      tick();
      host_rd(A_STATUS, rd);
      chk_cnt++;
      if (rd !== 32'h40) $display("FAIL abort_vs_done_status: got %h want 00000040", rd); else pass_cnt++;
      host_rd(A_LOGIT, rd);
      chk_cnt++;
      if (rd !== 32'hFFFF_FFFB) $display("FAIL abort_vs_done_logit: got %h want fffffffb", rd); else pass_cnt++;
   endtask

   task automatic test_idle_cmds();
      logic [31:0] rd;
      int irq0 = irq_cnt, nx0 = next_cnt, sc0 = sclr_cnt;
      host_wr(A_CTRL, 32'h02);
      host_wr(A_CTRL, 32'h03);
      host_wr(A_COMMIT, 32'h0);
      host_rd(A_STATUS, rd);
      chk_cnt++;
      if (rd !== 32'h0) $display("FAIL idle_cmd_status: got %h want 00000000", rd); else pass_cnt++;
      chk_cnt++;
      if (irq_cnt != irq0 || next_cnt != nx0 || sclr_cnt != sc0 || w_stream !== 32'h1122_3344)
         $display("FAIL idle_cmd_effects: got irq=%0d nx=%0d sc=%0d w=%h want 0 0 0 11223344",
                  irq_cnt - irq0, next_cnt - nx0, sclr_cnt - sc0, w_stream);
      else pass_cnt++;
   endtask

   task automatic test_reset_midrun();
      logic [31:0] rd;
      host_wr(A_CTRL, 32'h01);
      run_pass(4'd0, 10, "midrst");
      host_wr(A_CTRL, 32'h01);
      rst_ni = 1'b0;
      #2;
      chk_cnt++;
      if (conv_clear !== 1'b1 || w_stream !== 32'h0 || irq !== 1'b0)
         $display("FAIL async_reset: got clr=%b w=%h irq=%b want 1 0 0", conv_clear, w_stream, irq);
      else pass_cnt++;
      tick();
      rst_ni = 1'b1;
      tick();
      host_rd(A_STATUS, rd);
      chk_cnt++;
      if (rd !== 32'h0) $display("FAIL midrun_reset_status: got %h want 00000000", rd); else pass_cnt++;
   endtask

`ifdef NPU_SEQ_WDOG_EN
   task automatic test_wdog();
      logic [31:0] rd;
      int n = 0;
      int irq0 = irq_cnt;
      host_wr(A_CTRL, 32'h01);
      run_pass(4'd0, 0, "wdog");
      while (conv_clear !== 1'b1 && n < 40) begin
         tick();
         n++;
      end
      chk_cnt++;
      if (n != 16) $display("FAIL wdog_cycles: got %0d want 16", n); else pass_cnt++;
      host_rd(A_STATUS, rd);
      chk_cnt++;
      if (rd !== 32'h80) $display("FAIL wdog_status: got %h want 00000080", rd); else pass_cnt++;
      chk_cnt++;
      if (irq_cnt - irq0 !== 1) $display("FAIL wdog_irq: got %0d want 1", irq_cnt - irq0); else pass_cnt++;
   endtask
`endif

   initial begin
      test_reset();
      test_full_run();
      test_start_busy_abort();
      test_lcnt_clamp_abort_done();
      test_idle_cmds();
      test_reset_midrun();
`ifdef NPU_SEQ_WDOG_EN
      test_wdog();
`endif
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
